// File: rtl/f1_light_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : f1_pkg
// Purpose  : Shared state encoding and LFSR constants for the start-light
//            sequencer.
// Revision : 1.0  initial release
// ============================================================================
package f1_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  // x^7 + x^6 + 1 : feedback from bits 6 and 5 of a left-shifting register
  localparam logic [31:0] c_LFSR_TAPS = 32'h0000_0060;
  localparam logic [31:0] c_LFSR_SEED = 32'd1;

endpackage
`default_nettype wire

// File: rtl/f1_light_seq_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : lfsr
// Purpose  : Free-running Fibonacci LFSR used as the random hold source;
//            shifts left every clk, seeded non-zero so it never locks up.
// Revision : 1.0  initial release
// ============================================================================
module lfsr
  import f1_pkg::*;
#(
  parameter int                LFSR_W = 7,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(c_LFSR_TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] data_out
);

  logic w_fb;

  assign w_fb = ^(data_out & TAPS);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= LFSR_W'(c_LFSR_SEED);
    end else begin
      data_out <= {data_out[LFSR_W-2:0], w_fb};
    end
  end

endmodule
`default_nettype wire

// File: rtl/f1_light_seq.sv
`default_nettype none
// ============================================================================
// Module   : f1_light_seq
// Purpose  : Parametrised F1 start-light sequencer: fill lamps one per tick,
//            hold, then blank and pulse lights_out. Define F1_RANDOM_HOLD_EN
//            to take the hold length from an LFSR instead of HOLD_FIXED.
// Revision : 1.0  initial release
// ============================================================================
module f1_light_seq
  import f1_pkg::*;
#(
  parameter int N_LIGHTS   = 8,
  parameter int TICK_DIV   = 1,
  parameter int LFSR_W     = 7,
  parameter int HOLD_FIXED = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                trigger,
  input  logic                abort,
  output logic [N_LIGHTS-1:0] data_out,
  output logic                busy,
  output logic                lights_out
);

  localparam int c_PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_HFW  = $clog2(HOLD_FIXED + 1);
  localparam int c_HC_W = (LFSR_W > c_HFW) ? LFSR_W : c_HFW;

  state_t              r_state;
  logic [c_PW-1:0]     r_presc;
  logic [c_HC_W-1:0]   r_hold;
  logic [c_HC_W-1:0]   w_hold_val;
  logic [N_LIGHTS-1:0] w_shifted;
  logic                w_tick;

  assign w_tick = en && (r_presc == c_PW'(TICK_DIV - 1));

  generate
    if (N_LIGHTS == 1) begin : g_single
      assign w_shifted = 1'b1;
    end else begin : g_multi
      assign w_shifted = {data_out[N_LIGHTS-2:0], 1'b1};
    end
  endgenerate

`ifdef F1_RANDOM_HOLD_EN
  logic [LFSR_W-1:0] w_lfsr;

  lfsr #(
    .LFSR_W (LFSR_W)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .data_out (w_lfsr)
  );

  assign w_hold_val = c_HC_W'(w_lfsr);
`else
  assign w_hold_val = c_HC_W'(HOLD_FIXED);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_presc    <= '0;
      r_hold     <= '0;
      data_out   <= '0;
      busy       <= 1'b0;
      lights_out <= 1'b0;
    end else begin
      lights_out <= 1'b0;
      if (en) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
      end

      // abort wins over tick, and also suppresses a start while idle
      if (abort && (r_state != IDLE)) begin
        r_state  <= IDLE;
        data_out <= '0;
        busy     <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            data_out <= '0;
            if (trigger && en && !abort) begin
              r_state <= FILL;
              busy    <= 1'b1;
              r_presc <= '0;
            end
          end
          FILL: begin
            if (w_tick) begin
              data_out <= w_shifted;
              if (w_shifted == {N_LIGHTS{1'b1}}) begin
                r_state <= HOLD;
                r_hold  <= w_hold_val;
              end
            end
          end
          HOLD: begin
            if (w_tick) begin
              if (r_hold == c_HC_W'(1)) begin
                r_state    <= IDLE;
                data_out   <= '0;
                busy       <= 1'b0;
                lights_out <= 1'b1;
              end else begin
                r_hold <= r_hold - 1'b1;
              end
            end
          end
          default: begin
            r_state  <= IDLE;
            data_out <= '0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
